// File: rtl/onehot_sequencer_decoder.sv
// Registered N-to-2^N one-hot select sequencer with dwell handshake.
// Optional ONEHOT_SEQ_LIMIT_EN adds a runtime upper index limit.
module onehot_sequencer_decoder #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int SEL_WIDTH = 2,
    parameter int DWELL     = 1,
    localparam int OUT_WIDTH = 1 << SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           cmd,
    input  logic [SEL_WIDTH-1:0] sel,
`ifdef ONEHOT_SEQ_LIMIT_EN
    input  logic [SEL_WIDTH-1:0] limit,
`endif
    output logic [OUT_WIDTH-1:0] out_onehot,
    output logic                 out_valid,
    output logic [SEL_WIDTH-1:0] cur_index,
    output logic                 wrap
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] CMD_LOAD  = 2'd0;
    localparam logic [1:0] CMD_UP    = 2'd1;
    localparam logic [1:0] CMD_DN    = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [7:0] DWELL_INIT = 8'(DWELL - 1);

    if (SEL_WIDTH < 1 || SEL_WIDTH > 6 || DWELL < 1 || DWELL > 255)
    begin : g_bad_param
        $error("%s (uuid %0d): parameter out of range", NAME, UUID);
    end

    logic [0:0]           state_q, state_d;
    logic [SEL_WIDTH-1:0] idx_q, idx_d;
    logic [OUT_WIDTH-1:0] onehot_q, onehot_d;
    logic [7:0]           dwell_q, dwell_d;
    logic                 wrap_q, wrap_d;
    logic [SEL_WIDTH-1:0] eff_max;
    logic [SEL_WIDTH-1:0] load_idx;
    logic                 accept;
    logic                 is_idle;
    logic                 do_load, do_up, do_dn, do_clr;

`ifdef ONEHOT_SEQ_LIMIT_EN
    assign eff_max = limit;
`else
    assign eff_max = {SEL_WIDTH{1'b1}};
`endif

    assign is_idle  = (state_q == ST_IDLE);
    assign in_ready = is_idle | (dwell_q == 8'd0);
    assign accept   = in_valid & in_ready;
    assign load_idx = (sel > eff_max) ? eff_max : sel;

    assign do_load = accept & (cmd == CMD_LOAD);
    assign do_up   = accept & (cmd == CMD_UP);
    assign do_dn   = accept & (cmd == CMD_DN);
    assign do_clr  = accept & (cmd == CMD_CLEAR);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        dwell_d = (dwell_q != 8'd0) ? dwell_q - 8'd1 : 8'd0;
        unique case (1'b1)
            do_load: begin
                state_d = ST_ACTIVE;
                idx_d   = load_idx;
                dwell_d = DWELL_INIT;
            end
            do_up: begin
                state_d = ST_ACTIVE;
                dwell_d = DWELL_INIT;
                if (is_idle) begin
                    idx_d = '0;
                end else if (idx_q >= eff_max) begin
                    // an index stranded above a lowered limit also wraps
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            do_dn: begin
                state_d = ST_ACTIVE;
                dwell_d = DWELL_INIT;
                if (is_idle) begin
                    idx_d = eff_max;
                end else if (idx_q == '0) begin
                    idx_d  = eff_max;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            do_clr: begin
                state_d = ST_IDLE;
                dwell_d = 8'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        onehot_d = '0;
        if (state_d == ST_ACTIVE) begin
            onehot_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            dwell_q  <= 8'd0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            dwell_q  <= dwell_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_onehot = onehot_q;
    assign out_valid  = (state_q == ST_ACTIVE);
    assign cur_index  = idx_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer_decoder.sv
// Directed bench for onehot_sequencer_decoder (DWELL=1 table, DWELL=3 sequences).
module tb_onehot_sequencer_decoder;

    logic       clk = 1'b0;
    logic       rst1, rst3;
    logic       v1, v3;
    logic       rdy1, rdy3;
    logic [1:0] cmd1, cmd3;
    logic [1:0] sel1, sel3;
    logic [1:0] lim1, lim3;
    logic [3:0] oh1, oh3;
    logic       ov1, ov3;
    logic [1:0] idx1, idx3;
    logic       wr1, wr3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onehot_sequencer_decoder #(.SEL_WIDTH(2), .DWELL(1)) u_d1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1),
        .cmd(cmd1), .sel(sel1),
`ifdef ONEHOT_SEQ_LIMIT_EN
        .limit(lim1),
`endif
        .out_onehot(oh1), .out_valid(ov1), .cur_index(idx1), .wrap(wr1)
    );

    onehot_sequencer_decoder #(.SEL_WIDTH(2), .DWELL(3)) u_d3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_ready(rdy3),
        .cmd(cmd3), .sel(sel3),
`ifdef ONEHOT_SEQ_LIMIT_EN
        .limit(lim3),
`endif
        .out_onehot(oh3), .out_valid(ov3), .cur_index(idx3), .wrap(wr3)
    );

    typedef struct {
        logic       valid;
        logic [1:0] cmd;
        logic [1:0] sel;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       ov;
        logic       wr;
        logic       rdy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] oh,
                        input logic [1:0] idx, input logic ov,
                        input logic wr, input logic rdy);
        chk({tag, ".onehot"}, 32'(oh1), 32'(oh));
        chk({tag, ".index"},  32'(idx1), 32'(idx));
        chk({tag, ".valid"},  32'(ov1), 32'(ov));
        chk({tag, ".wrap"},   32'(wr1), 32'(wr));
        chk({tag, ".ready"},  32'(rdy1), 32'(rdy));
    endtask

    task automatic chk3(input string tag, input logic [3:0] oh,
                        input logic [1:0] idx, input logic ov,
                        input logic wr, input logic rdy);
        chk({tag, ".onehot"}, 32'(oh3), 32'(oh));
        chk({tag, ".index"},  32'(idx3), 32'(idx));
        chk({tag, ".valid"},  32'(ov3), 32'(ov));
        chk({tag, ".wrap"},   32'(wr3), 32'(wr));
        chk({tag, ".ready"},  32'(rdy3), 32'(rdy));
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              vld  cmd   sel   onehot   idx  ov  wr  rdy
        vecs[0]  = '{1'b1, 2'd0, 2'd2, 4'b0100, 2'd2, 1, 0, 1};
        vecs[1]  = '{1'b1, 2'd0, 2'd3, 4'b1000, 2'd3, 1, 0, 1};
        vecs[2]  = '{1'b1, 2'd1, 2'd0, 4'b0001, 2'd0, 1, 1, 1};
        vecs[3]  = '{1'b0, 2'd1, 2'd0, 4'b0001, 2'd0, 1, 0, 1};
        vecs[4]  = '{1'b1, 2'd2, 2'd0, 4'b1000, 2'd3, 1, 1, 1};
        vecs[5]  = '{1'b1, 2'd2, 2'd0, 4'b0100, 2'd2, 1, 0, 1};
        vecs[6]  = '{1'b1, 2'd3, 2'd0, 4'b0000, 2'd2, 0, 0, 1};
        vecs[7]  = '{1'b1, 2'd2, 2'd1, 4'b1000, 2'd3, 1, 0, 1};
        vecs[8]  = '{1'b1, 2'd2, 2'd1, 4'b0100, 2'd2, 1, 0, 1};
        vecs[9]  = '{1'b1, 2'd3, 2'd0, 4'b0000, 2'd2, 0, 0, 1};
        vecs[10] = '{1'b1, 2'd1, 2'd3, 4'b0001, 2'd0, 1, 0, 1};
        vecs[11] = '{1'b1, 2'd1, 2'd0, 4'b0010, 2'd1, 1, 0, 1};
        vecs[12] = '{1'b0, 2'd3, 2'd0, 4'b0010, 2'd1, 1, 0, 1};
        vecs[13] = '{1'b1, 2'd0, 2'd0, 4'b0001, 2'd0, 1, 0, 1};
        vecs[14] = '{1'b1, 2'd3, 2'd0, 4'b0000, 2'd0, 0, 0, 1};
        vecs[15] = '{1'b0, 2'd0, 2'd0, 4'b0000, 2'd0, 0, 0, 1};

        rst1 = 1'b0; rst3 = 1'b0;
        v1 = 1'b0; v3 = 1'b0;
        cmd1 = 2'd0; cmd3 = 2'd0;
        sel1 = 2'd0; sel3 = 2'd0;
        lim1 = 2'd3; lim3 = 2'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1; rst3 = 1'b1;
        #1;
        chk1("reset1", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        chk3("reset3", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v1   = vecs[i].valid;
            cmd1 = vecs[i].cmd;
            sel1 = vecs[i].sel;
            edge1();
            chk1($sformatf("vec%0d", i), vecs[i].oh, vecs[i].idx,
                 vecs[i].ov, vecs[i].wr, vecs[i].rdy);
            chk($sformatf("vec%0d.onehot_count", i),
                32'($countones(oh1) <= 1), 32'd1);
        end
        @(negedge clk);
        v1 = 1'b0;

        // DWELL=3: LOAD 1, then STEP_UP held until accepted
        @(negedge clk);
        v3 = 1'b1; cmd3 = 2'd0; sel3 = 2'd1;
        edge1();
        chk3("d3_load", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        cmd3 = 2'd1;
        edge1();
        chk3("d3_hold1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        edge1();
        chk3("d3_hold2", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        edge1();
        chk3("d3_step", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);

        // CLEAR mid-dwell waits for in_ready
        cmd3 = 2'd3;
        edge1();
        chk3("d3_clr_hold1", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        edge1();
        chk3("d3_clr_hold2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        edge1();
        chk3("d3_clr", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);

        // Async reset while ACTIVE and mid-dwell
        cmd3 = 2'd0; sel3 = 2'd3;
        edge1();
        chk3("d3_load3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        v3 = 1'b0;
        #2;
        rst3 = 1'b0;
        #1;
        chk3("d3_async_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst3 = 1'b1;

`ifdef ONEHOT_SEQ_LIMIT_EN
        @(negedge clk);
        lim1 = 2'd2; v1 = 1'b1; cmd1 = 2'd0; sel1 = 2'd3;
        edge1();
        chk1("lim_load", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        cmd1 = 2'd1;
        edge1();
        chk1("lim_up", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
        cmd1 = 2'd2;
        edge1();
        chk1("lim_dn", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
        v1 = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_sequencer_decoder.md
Name: onehot_sequencer_decoder

Overview:
Parametrised registered N-to-2^N decoder. It drives exactly one of 2^SEL_WIDTH one-hot outputs, or none when idle.
- Replaces fixed combinational 2-to-4 decoders in LEG select paths (register-file write enables, bus source select).
- Adds registered outputs, step-up/step-down sequencing with wrap detection, a minimum-dwell handshake and a clear command.

Parameters:
UUID, 0, instance identifier (codebase convention, not used functionally)
NAME, "", instance name (codebase convention, not used functionally)
SEL_WIDTH, 2, select/index width; OUT_WIDTH = 1 << SEL_WIDTH is a derived localparam; legal range 1..6
DWELL, 1, minimum cycles an output stays asserted before the next command is accepted; legal range 1..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command accept; a transfer occurs on in_valid & in_ready at the clk rising edge
cmd  input  2  0 = LOAD, 1 = STEP_UP, 2 = STEP_DN, 3 = CLEAR
sel  input  SEL_WIDTH  target index for LOAD
out_onehot  output  OUT_WIDTH  registered one-hot select; bit i set means index i is active
out_valid  output  1  high when in ACTIVE state (exactly one out_onehot bit set)
cur_index  output  SEL_WIDTH  registered current index
wrap  output  1  one-cycle pulse on step wrap-around

Behaviour:
- Reset (rst low, asynchronous; release is synchronous to clk):
  - state = IDLE
  - out_onehot = 0, out_valid = 0, cur_index = 0, wrap = 0
  - dwell counter = 0
- States:
  - IDLE: no output asserted.
  - ACTIVE: exactly one output asserted, out_onehot = 1 << cur_index.
- Handshake:
  - in_ready = (state == IDLE) | (dwell_cnt == 0). It is combinational from registers only, never from in_valid.
  - While in_ready is low, commands are held off and state does not change.
- Latency: a command accepted at edge k is visible on out_onehot, cur_index, out_valid and wrap immediately after edge k (1 cycle). No combinational path from inputs to outputs.
- Dwell counter:
  - On each accepted LOAD/STEP, dwell_cnt loads DWELL-1 and then decrements once per cycle to 0.
  - With DWELL = 1, a command can be accepted every cycle.
- LOAD: cur_index <= sel; state goes to ACTIVE; wrap <= 0.
- STEP_UP:
  - From ACTIVE: cur_index <= cur_index + 1 modulo max+1. If cur_index was max (2^SEL_WIDTH - 1), the result is 0 and wrap <= 1.
  - From IDLE: cur_index <= 0, state goes to ACTIVE, no wrap.
- STEP_DN:
  - From ACTIVE: cur_index <= cur_index - 1. If cur_index was 0, the result is max and wrap <= 1.
  - From IDLE: cur_index <= max, state goes to ACTIVE, no wrap.
- CLEAR:
  - state goes to IDLE; out_onehot = 0, out_valid = 0, dwell_cnt = 0.
  - cur_index retains its value (observable only on cur_index).
- wrap is high for exactly one cycle after the wrapping command. It is 0 in every other cycle, including idle cycles with no accepted command.
- No command accepted: all outputs hold, except wrap, which returns to 0.
- Reset mid-dwell: immediate return to reset values; in_ready = 1 while in IDLE.
- out_onehot is never multi-hot in any cycle.

Optional Feature:
Macro: ONEHOT_SEQ_LIMIT_EN.
- Defined:
  - Adds input port `limit` [SEL_WIDTH], sampled on each accepted command.
  - It defines an effective max = limit:
    - STEP_UP wraps from limit to 0.
    - STEP_DN wraps from 0 to limit.
    - STEP_DN from IDLE starts at limit.
    - LOAD with sel > limit loads limit.
  - If cur_index > limit when STEP_UP is accepted, the result is 0 with wrap = 1.
- Undefined: no `limit` port; effective max = 2^SEL_WIDTH - 1; behaviour exactly as above.

Test Plan:
- Reset, then LOAD sel=2 (SEL_WIDTH=2, DWELL=1) -> next cycle: out_onehot=4'b0100, cur_index=2, out_valid=1, in_ready=1.
- LOAD 3, then STEP_UP on consecutive cycles -> out_onehot 4'b1000 then 4'b0001; wrap=1 for exactly that one cycle only.
- From IDLE, STEP_DN -> out_onehot=4'b1000, wrap=0. A second STEP_DN -> 4'b0100.
- DWELL=3: LOAD 1 with in_valid held high and STEP_UP queued -> in_ready low for 2 cycles. STEP_UP is accepted on the 3rd cycle; out_onehot=4'b0100 appears 3 cycles after 4'b0010.
- CLEAR mid-dwell is not accepted until in_ready=1. Once accepted -> out_onehot=0, out_valid=0, cur_index unchanged. Asynchronously asserting rst during ACTIVE -> outputs zero the same cycle, without waiting for a clk edge.
- With ONEHOT_SEQ_LIMIT_EN, limit=2, SEL_WIDTH=2: LOAD 3 -> cur_index=2. STEP_UP -> cur_index=0, wrap=1. STEP_DN -> cur_index=2, wrap=1.
